mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter sharing one data-memory port among protocol controllers, core-side DMA and vector load/store lanes.
- Replaces the current single fixed controller-to-datamem connection.
- Round-robin fairness, optional locked bursts, one transfer per cycle.
- Sits between requesters and the synchronous-read data memory, clocked on the core clock domain.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- ADDR_W, 12, word-address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MAX_BURST, 4, maximum consecutive locked grants to one channel (1..16)

Ports:
- clk  input  1  core clock
- nrst  input  1  asynchronous active-low reset
- ch_req  input  NUM_CH  per-channel request, held until granted
- ch_lock  input  NUM_CH  request to keep priority for the next access
- ch_addr  input  NUM_CH*ADDR_W  flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_we  input  NUM_CH*(DATA_W/8)  flattened byte-write enables; all-zero means read
- ch_wdata  input  NUM_CH*DATA_W  flattened write data
- ch_gnt  output  NUM_CH  one-hot grant, combinational, same cycle as winning request
- ch_rvalid  output  NUM_CH  one-hot read-data valid
- ch_rdata  output  DATA_W  read data, broadcast to all channels
- mem_addr  output  ADDR_W  registered memory address
- mem_we  output  DATA_W/8  registered byte enables
- mem_wdata  output  DATA_W  registered write data
- mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_addr
- busy_owner  output  $clog2(NUM_CH)  index of last granted channel

Behaviour:
- Reset (nrst low, async):
  - mem_addr, mem_we, mem_wdata, ch_rvalid, busy_owner = 0; ch_gnt forced 0.
  - Internal rr_ptr = 0, burst_cnt = 0, lock_active = 0, rd_pend = 0.
- Transfer: occurs in cycle t when ch_req[i] & ch_gnt[i]. At most one ch_gnt bit is set per cycle.
- Selection:
  - lock_active set and owner requesting: owner wins.
  - Otherwise: first requesting channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
- Pipeline:
  - t+1: mem_addr/mem_we/mem_wdata hold the transfer's values; busy_owner = i.
  - No transfer at t: mem_we = 0 at t+1 (no write). mem_addr/mem_wdata hold their last values.
  - Read transfer: rd_pend carries i; ch_rvalid[i] = 1 at t+2, ch_rdata = mem_rdata. Write transfers never raise ch_rvalid.
- Throughput: back-to-back transfers every cycle; read latency fixed at 2 cycles from grant.
- rr_ptr update after each transfer:
  - Without lock continuation: rr_ptr = (i+1) mod NUM_CH.
  - During a locked burst: rr_ptr is unchanged.
- Lock/burst:
  - ch_lock[i] high at transfer and burst_cnt < MAX_BURST-1: lock_active = 1, burst_cnt++.
  - Otherwise lock_active = 0, burst_cnt = 0, rr_ptr advances.
  - Owner with no request in a cycle ends the lock: normal round-robin, burst_cnt = 0.
  - MAX_BURST = 1 disables locking.
- Boundaries:
  - No requests: no grant, state unchanged.
  - All channels requesting: pure rotation 0,1,2,3,0...
  - rr_ptr wraps NUM_CH-1 to 0.
  - Reset mid-burst or with a read pending: the pending ch_rvalid is dropped.
- Requesters treat ch_gnt as ready: ch_addr/ch_we/ch_wdata stable while ch_req high.

Optional Feature:
- ARB_PRIO0_EN defined:
  - Channel 0 requesting always wins, preempting round-robin and any active lock (the lock ends, burst_cnt = 0).
  - rr_ptr unchanged on channel-0 wins.
- ARB_PRIO0_EN undefined: channel 0 is an ordinary round-robin participant.

Test Plan:
- Reset then single read: ch_req=0010, ch_addr[1]=0x05A, mem_rdata=0xDEADBEEF → ch_gnt=0010 same cycle; mem_addr=0x05A, mem_we=0 next cycle; ch_rvalid=0010, ch_rdata=0xDEADBEEF two cycles after grant.
- All four requesting continuously, no lock → grants 0,1,2,3,0,1 on consecutive cycles; busy_owner follows one cycle later.
- Ch2 write: ch_we[2]=4'b0011, wdata=0x12345678, addr=0x100 → mem_we=0011, mem_wdata=0x12345678, mem_addr=0x100 next cycle; no ch_rvalid.
- Locked burst, MAX_BURST=4: ch1 lock+req held, ch3 req held → grants 1,1,1,1,3,1; burst capped at 4.
- Async reset asserted the cycle after a read grant → ch_rvalid stays 0; mem_we=0; first post-reset grant with all requesting goes to ch0.
- ARB_PRIO0_EN defined: ch2 mid-lock, ch0 raises req → ch0 granted next arbitration cycle, then ch2 resumes via round-robin with burst_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin N-channel arbiter for one synchronous-read
//                    data-memory port, with optional locked bursts.
// Optional feature : ARB_PRIO0_EN (channel 0 has absolute priority)
// Revision         : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_lock,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_we,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
  output logic [NUM_CH-1:0]              ch_gnt,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W/8-1:0]            mem_we,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [$clog2(NUM_CH)-1:0]      busy_owner
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OWN_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);
  localparam logic [OWN_W-1:0] LAST_CH   = OWN_W'(NUM_CH - 1);

  logic [OWN_W-1:0]  rr_ptr_q,      rr_ptr_d;
  logic [CNT_W-1:0]  burst_cnt_q,   burst_cnt_d;
  logic              lock_active_q, lock_active_d;
  logic [OWN_W-1:0]  owner_q,       owner_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [BE_W-1:0]   mem_we_q,      mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic              rd_pend_q,     rd_pend_d;
  logic [OWN_W-1:0]  rd_ch_q,       rd_ch_d;
  logic [NUM_CH-1:0] rvalid_q,      rvalid_d;

  logic              rr_hit;
  logic [OWN_W-1:0]  rr_idx;
  logic              keep_lock;
  logic              prio0_win;
  logic              sel_valid;
  logic [OWN_W-1:0]  sel_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  cnt_eff;

`ifdef ARB_PRIO0_EN
  assign prio0_win = ch_req[0];
`else
  assign prio0_win = 1'b0;
`endif

  // The lock only survives while its owner keeps requesting.
  assign keep_lock = lock_active_q & ch_req[owner_q];
  assign cnt_eff   = keep_lock ? burst_cnt_q : '0;

  always_comb begin : arb_scan
    int j;
    logic [OWN_W-1:0] cand;
    rr_hit = 1'b0;
    rr_idx = '0;
    j      = 0;
    cand   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      cand = OWN_W'(j);
      if (!rr_hit && ch_req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (prio0_win) begin
      sel_valid = 1'b1;
      sel_idx   = '0;
    end else if (keep_lock) begin
      sel_valid = 1'b1;
      sel_idx   = owner_q;
    end else if (rr_hit) begin
      sel_valid = 1'b1;
      sel_idx   = rr_idx;
    end
  end

  assign xfer      = sel_valid & nrst;
  assign sel_addr  = ch_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
  assign sel_we    = ch_we[int'(sel_idx)*BE_W +: BE_W];
  assign sel_wdata = ch_wdata[int'(sel_idx)*DATA_W +: DATA_W];

  always_comb begin
    ch_gnt = '0;
    if (xfer) ch_gnt[sel_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    lock_active_d = lock_active_q;
    owner_d       = owner_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = '0;
    mem_wdata_d   = mem_wdata_q;
    rd_pend_d     = 1'b0;
    rd_ch_d       = rd_ch_q;
    rvalid_d      = '0;
    if (rd_pend_q) rvalid_d[rd_ch_q] = 1'b1;

    if (xfer) begin
      mem_addr_d  = sel_addr;
      mem_we_d    = sel_we;
      mem_wdata_d = sel_wdata;
      owner_d     = sel_idx;
      rd_pend_d   = ~|sel_we;
      rd_ch_d     = sel_idx;
      if (prio0_win) begin
        lock_active_d = 1'b0;
        burst_cnt_d   = '0;
      end else if (ch_lock[sel_idx] && (cnt_eff < BURST_LIM)) begin
        lock_active_d = 1'b1;
        burst_cnt_d   = cnt_eff + CNT_W'(1);
      end else begin
        lock_active_d = 1'b0;
        burst_cnt_d   = '0;
        rr_ptr_d      = (sel_idx == LAST_CH) ? '0 : sel_idx + OWN_W'(1);
      end
    end else if (lock_active_q && !keep_lock) begin
      lock_active_d = 1'b0;
      burst_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      lock_active_q <= 1'b0;
      owner_q       <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= '0;
      mem_wdata_q   <= '0;
      rd_pend_q     <= 1'b0;
      rd_ch_q       <= '0;
      rvalid_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      lock_active_q <= lock_active_d;
      owner_q       <= owner_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pend_q     <= rd_pend_d;
      rd_ch_q       <= rd_ch_d;
      rvalid_q      <= rvalid_d;
    end
  end

  // Memory returns data the cycle after mem_addr, aligned with rvalid.
  assign ch_rdata   = mem_rdata;
  assign ch_rvalid  = rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy_owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: directed steps, read scoreboard, memory model.
module tb_mem_port_arbiter;

  logic         clk;
  logic         nrst;
  logic [3:0]   ch_req;
  logic [3:0]   ch_lock;
  logic [47:0]  ch_addr;
  logic [15:0]  ch_we;
  logic [127:0] ch_wdata;
  logic [3:0]   ch_gnt;
  logic [3:0]   ch_rvalid;
  logic [31:0]  ch_rdata;
  logic [11:0]  mem_addr;
  logic [3:0]   mem_we;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic [1:0]   busy_owner;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  mem_port_arbiter #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .nrst(nrst), .ch_req(ch_req), .ch_lock(ch_lock),
    .ch_addr(ch_addr), .ch_we(ch_we), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy_owner(busy_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] init_word(input logic [11:0] a);
    return (a == 12'h05A) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Synchronous-read memory model driven by the DUT's registered port
  logic [31:0] mem    [0:4095];
  bit          mem_wr [0:4095];

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return mem_wr[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (|mem_we) begin
      mem[mem_addr]    <= merge(mem_word(mem_addr), mem_wdata, mem_we);
      mem_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_word(mem_addr);
  end

  // Shadow of memory contents, updated in grant order
  logic [31:0] shadow    [0:4095];
  bit          shadow_wr [0:4095];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (nrst) begin
      if (|ch_rvalid) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL rv_spurious: observed rvalid=%0h expected no rvalid", ch_rvalid);
        end
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          chk("rv_chan", ch_rvalid, 64'(1) << e.ch);
          chk("rv_data", ch_rdata, e.data);
          chk("rv_latency", cyc - e.cyc, 2);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_req[i] && ch_gnt[i]) begin
          logic [11:0] a;
          logic [31:0] cur;
          a   = ch_addr[i*12 +: 12];
          cur = shadow_wr[a] ? shadow[a] : init_word(a);
          if (ch_we[i*4 +: 4] == 4'b0000) begin
            sb_q.push_back('{ch: i, data: cur, cyc: cyc});
          end else begin
            shadow[a]    = merge(cur, ch_wdata[i*32 +: 32], ch_we[i*4 +: 4]);
            shadow_wr[a] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge / two after.
  task automatic do_reset();
    nrst = 1'b0;
    sb_q.delete();
    ch_req  = '0;
    ch_lock = '0;
    ch_we   = '0;
    tick();
    tick();
    #1;
    nrst = 1'b1;
  endtask

  logic [3:0] lk_req  [12] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
                               4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
  int         lk_exp  [12] = '{1, 1, 1, 1, 3, 1, 3, 1, 1, 1, 1, 3};
`ifdef ARB_PRIO0_EN
  logic [3:0] pr_req  [8]  = '{4'b0100, 4'b0100, 4'b0101, 4'b1100,
                               4'b1100, 4'b1100, 4'b1100, 4'b1100};
  int         pr_exp  [8]  = '{2, 2, 0, 2, 2, 2, 2, 3};
`endif

  initial begin : main
    int exp;
    nrst     = 1'b0;
    ch_req   = 4'hF;
    ch_lock  = '0;
    ch_we    = '0;
    ch_addr  = {12'h013, 12'h012, 12'h011, 12'h010};
    ch_wdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    tick();
    tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", ch_rvalid, 0);
    chk("rst_busy", busy_owner, 0);
    chk("rst_gnt_forced", ch_gnt, 0);
    #1;
    ch_req = '0;
    nrst   = 1'b1;

    // Single read on channel 1
    ch_addr[12 +: 12] = 12'h05A;
    ch_req = 4'b0010;
    #1 chk("rd_gnt", ch_gnt, 4'b0010);
    tick();
    chk("rd_mem_addr", mem_addr, 12'h05A);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_busy", busy_owner, 1);
    #1 ch_req = '0;
    #1 chk("idle_gnt", ch_gnt, 0);
    tick();
    chk("rd_rvalid", ch_rvalid, 4'b0010);
    chk("rd_rdata", ch_rdata, 32'hDEADBEEF);

    // Async reset the cycle after a read grant drops the pending rvalid
    #1 ch_req = 4'b0010;
    #1 chk("rst2_gnt", ch_gnt, 4'b0010);
    tick();
    nrst = 1'b0;
    sb_q.delete();
    ch_req = '0;
    #1;
    chk("rst2_mem_we", mem_we, 0);
    chk("rst2_rvalid", ch_rvalid, 0);
    chk("rst2_mem_addr", mem_addr, 0);
    tick();
    chk("rst2_rvalid_dropped", ch_rvalid, 0);
    #1;
    ch_addr[12 +: 12] = 12'h011;
    ch_req = 4'hF;
    nrst   = 1'b1;
    #1;

    // All channels requesting: rotation with wrap
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_PRIO0_EN
      exp = 0;
`else
      exp = k % 4;
`endif
      chk("rot_gnt", ch_gnt, 64'(1) << exp);
      tick();
      chk("rot_busy", busy_owner, exp);
      chk("rot_mem_addr", mem_addr, 12'h010 + exp);
      #2;
    end
    ch_req = '0;
    tick();
    tick();
    tick();
    #2 chk("norq_gnt", ch_gnt, 0);
    tick();
`ifdef ARB_PRIO0_EN
    chk("norq_busy_hold", busy_owner, 0);
`else
    chk("norq_busy_hold", busy_owner, 1);
`endif
    chk("norq_mem_we", mem_we, 0);

    // Partial write on channel 2, then read it back on channel 0
    #1;
    ch_addr[24 +: 12]  = 12'h100;
    ch_we[8 +: 4]      = 4'b0011;
    ch_wdata[64 +: 32] = 32'h12345678;
    ch_req = 4'b0100;
    #1 chk("wr_gnt", ch_gnt, 4'b0100);
    tick();
    chk("wr_mem_we", mem_we, 4'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_mem_addr", mem_addr, 12'h100);
    chk("wr_busy", busy_owner, 2);
    #1;
    ch_req = '0;
    ch_we  = '0;
    tick();
    chk("wr_no_rvalid", ch_rvalid, 0);
    chk("wr_idle_we", mem_we, 0);
    chk("wr_idle_addr_hold", mem_addr, 12'h100);
    #1;
    ch_addr[0 +: 12] = 12'h100;
    ch_req = 4'b0001;
    #1 chk("rb_gnt", ch_gnt, 4'b0001);
    tick();
    #1 ch_req = '0;
    tick();
    tick();

    // Locked bursts, capped at MAX_BURST; owner drop ends the lock
    do_reset();
    ch_addr[0 +: 12]  = 12'h010;
    ch_addr[24 +: 12] = 12'h012;
    for (int i = 0; i < 12; i++) begin
      ch_req  = lk_req[i];
      ch_lock = 4'b0010;
      #1 chk("lock_gnt", ch_gnt, 64'(1) << lk_exp[i]);
      tick();
      chk("lock_busy", busy_owner, lk_exp[i]);
      #1;
    end
    ch_req  = '0;
    ch_lock = '0;
    tick();
    tick();
    tick();

`ifdef ARB_PRIO0_EN
    // Channel 0 preempts a lock; channel 2 resumes with a fresh burst
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ch_req  = pr_req[i];
      ch_lock = 4'b0100;
      #1 chk("prio_gnt", ch_gnt, 64'(1) << pr_exp[i]);
      tick();
      chk("prio_busy", busy_owner, pr_exp[i]);
      #1;
    end
    ch_req  = '0;
    ch_lock = '0;
    tick();
    tick();
    tick();
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
